// File: rtl/countdown_timer_ctrl.sv
// Pausable, abortable seconds countdown driven by the 100 ms tick.
// Optional warning pulse is built only when TIMER_WARN_EN is defined.
module countdown_timer_ctrl #(
  parameter int SEC_W         = 8,
  parameter int TICKS_PER_SEC = 10,
  parameter int WARN_SECS     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_100ms,
  input  logic             start,
  input  logic             pause,
  input  logic             resume,
  input  logic             abort,
  input  logic [SEC_W-1:0] load_secs,
  output logic [SEC_W-1:0] secs_remaining,
  output logic [3:0]       tenths,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             timeout_pulse,
  output logic             warn_pulse,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0]       LAST_TICK = 4'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] ONE_SEC   = SEC_W'(1);

  state_e           state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [3:0]       tenths_q, tenths_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

`ifdef TIMER_WARN_EN
  localparam logic [SEC_W-1:0] WARN_VAL = SEC_W'(WARN_SECS);
  logic warn_q, warn_d;
`endif

  always_comb begin
    state_d   = state_q;
    secs_d    = secs_q;
    tenths_d  = tenths_q;
    timeout_d = 1'b0;
`ifdef TIMER_WARN_EN
    warn_d    = 1'b0;
`endif
    // Priority: abort > start > pause/resume > tick; a command always eats a coincident tick.
    if (abort) begin
      state_d  = S_IDLE;
      secs_d   = '0;
      tenths_d = '0;
    end else if (start) begin
      tenths_d = '0;
      if (load_secs == '0) begin
        state_d   = S_EXPIRED;
        secs_d    = '0;
        timeout_d = 1'b1;
      end else begin
        state_d = S_RUN;
        secs_d  = load_secs;
`ifdef TIMER_WARN_EN
        warn_d  = (load_secs <= WARN_VAL);
`endif
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick_100ms) begin
            if (tenths_q != LAST_TICK) begin
              tenths_d = tenths_q + 4'd1;
            end else begin
              tenths_d = '0;
              // Guarded decrement: the count never wraps below zero.
              if (secs_q >= ONE_SEC) secs_d = secs_q - ONE_SEC;
              if (secs_q == ONE_SEC) begin
                state_d   = S_EXPIRED;
                timeout_d = 1'b1;
              end
`ifdef TIMER_WARN_EN
              warn_d = (secs_d == WARN_VAL) && (state_d == S_RUN);
`endif
            end
          end
        end
        S_PAUSE: begin
          if (resume && !pause) state_d = S_RUN;
        end
        S_EXPIRED: begin
          secs_d   = '0;
          tenths_d = '0;
        end
        default: ;
      endcase
    end
    busy_d   = (state_d == S_RUN) || (state_d == S_PAUSE);
    paused_d = (state_d == S_PAUSE);
    done_d   = (state_d == S_EXPIRED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      secs_q    <= '0;
      tenths_q  <= '0;
      busy_q    <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      tenths_q  <= tenths_d;
      busy_q    <= busy_d;
      paused_q  <= paused_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef TIMER_WARN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) warn_q <= 1'b0;
    else     warn_q <= warn_d;
  end
  assign warn_pulse = warn_q;
`else
  assign warn_pulse = 1'b0;
`endif

  assign secs_remaining = secs_q;
  assign tenths         = tenths_q;
  assign busy           = busy_q;
  assign paused         = paused_q;
  assign done           = done_q;
  assign timeout_pulse  = timeout_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl: countdown, pause/resume, abort, reset, restart, warning.
module tb_countdown_timer_ctrl;

  localparam int SEC_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tick_100ms = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             resume = 1'b0;
  logic             abort = 1'b0;
  logic [SEC_W-1:0] load_secs = '0;
  logic [SEC_W-1:0] secs_remaining;
  logic [3:0]       tenths;
  logic             busy, paused, done, timeout_pulse, warn_pulse;
  logic [1:0]       state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int timeout_cnt = 0;
  int warn_cnt = 0;

  countdown_timer_ctrl #(.SEC_W(SEC_W), .TICKS_PER_SEC(10), .WARN_SECS(5)) dut (
    .clk(clk), .rst(rst), .tick_100ms(tick_100ms), .start(start), .pause(pause),
    .resume(resume), .abort(abort), .load_secs(load_secs),
    .secs_remaining(secs_remaining), .tenths(tenths), .busy(busy), .paused(paused),
    .done(done), .timeout_pulse(timeout_pulse), .warn_pulse(warn_pulse),
    .state_dbg(state_dbg)
  );

  // clock / pulse counters
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timeout_pulse === 1'b1) timeout_cnt++;
    if (warn_pulse === 1'b1) warn_cnt++;
  end

  // driver tasks: step returns 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_tick();
    tick_100ms = 1'b1;
    step();
    tick_100ms = 1'b0;
  endtask

  task automatic do_start(input logic [SEC_W-1:0] v);
    load_secs = v;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_cmp++;
    if ({secs_remaining, tenths, busy, paused, done, timeout_pulse, warn_pulse} !== '0) begin
      $display("FAIL reset_outputs got secs=%0d tenths=%0d busy=%0b paused=%0b done=%0b to=%0b warn=%0b req all 0",
               secs_remaining, tenths, busy, paused, done, timeout_pulse, warn_pulse);
      n_err++;
    end
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      $display("FAIL reset_state got %0d req 0", state_dbg); n_err++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_countdown();
    do_start(8'd3);
    n_cmp++;
    if (busy !== 1'b1 || secs_remaining !== 8'd3 || tenths !== 4'd0) begin
      $display("FAIL cd_load got busy=%0b secs=%0d tenths=%0d req 1/3/0", busy, secs_remaining, tenths); n_err++;
    end
    timeout_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      do_tick();
      if (i == 10 || i == 20) begin
        n_cmp++;
        if (secs_remaining !== 8'(3 - i / 10) || tenths !== 4'd0) begin
          $display("FAIL cd_step%0d got secs=%0d tenths=%0d req %0d/0", i, secs_remaining, tenths, 3 - i / 10); n_err++;
        end
      end
      if (i == 25) begin
        n_cmp++;
        if (secs_remaining !== 8'd1 || tenths !== 4'd5 || timeout_pulse !== 1'b0) begin
          $display("FAIL cd_mid got secs=%0d tenths=%0d to=%0b req 1/5/0", secs_remaining, tenths, timeout_pulse); n_err++;
        end
      end
      if (i == 30) begin
        n_cmp++;
        if (timeout_pulse !== 1'b1 || done !== 1'b1 || secs_remaining !== 8'd0 || busy !== 1'b0) begin
          $display("FAIL cd_expire got to=%0b done=%0b secs=%0d busy=%0b req 1/1/0/0", timeout_pulse, done, secs_remaining, busy); n_err++;
        end
      end else begin
        idle(4);
      end
    end
    step();
    n_cmp++;
    if (timeout_pulse !== 1'b0 || done !== 1'b1) begin
      $display("FAIL cd_after got to=%0b done=%0b req 0/1", timeout_pulse, done); n_err++;
    end
    // expired state ignores tick/pause/resume
    tick_100ms = 1'b1; pause = 1'b1; resume = 1'b1;
    idle(3);
    tick_100ms = 1'b0; pause = 1'b0; resume = 1'b0;
    step();
    n_cmp++;
    if (done !== 1'b1 || paused !== 1'b0 || tenths !== 4'd0 || timeout_cnt !== 1) begin
      $display("FAIL cd_hold got done=%0b paused=%0b tenths=%0d pulses=%0d req 1/0/0/1", done, paused, tenths, timeout_cnt); n_err++;
    end
    do_abort();
    n_cmp++;
    if (done !== 1'b0 || state_dbg !== 2'd0) begin
      $display("FAIL cd_abort got done=%0b state=%0d req 0/0", done, state_dbg); n_err++;
    end
  endtask

  task automatic test_pause_resume();
    do_start(8'd2);
    for (int i = 0; i < 7; i++) begin do_tick(); step(); end
    pause = 1'b1; step(); pause = 1'b0;
    n_cmp++;
    if (paused !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL pr_paused got paused=%0b busy=%0b req 1/1", paused, busy); n_err++;
    end
    for (int i = 0; i < 20; i++) begin do_tick(); step(); end
    n_cmp++;
    if (secs_remaining !== 8'd2 || tenths !== 4'd7) begin
      $display("FAIL pr_frozen got secs=%0d tenths=%0d req 2/7", secs_remaining, tenths); n_err++;
    end
    // pause beats resume when both are asserted
    pause = 1'b1; resume = 1'b1; step(); pause = 1'b0; resume = 1'b0;
    n_cmp++;
    if (paused !== 1'b1) begin
      $display("FAIL pr_both got paused=%0b req 1", paused); n_err++;
    end
    resume = 1'b1; tick_100ms = 1'b1; step(); resume = 1'b0; tick_100ms = 1'b0;
    n_cmp++;
    if (paused !== 1'b0 || busy !== 1'b1 || tenths !== 4'd7) begin
      $display("FAIL pr_resume got paused=%0b busy=%0b tenths=%0d req 0/1/7", paused, busy, tenths); n_err++;
    end
    timeout_cnt = 0;
    for (int i = 1; i <= 13; i++) begin
      do_tick();
      if (i == 3) begin
        n_cmp++;
        if (secs_remaining !== 8'd1 || tenths !== 4'd0) begin
          $display("FAIL pr_second got secs=%0d tenths=%0d req 1/0", secs_remaining, tenths); n_err++;
        end
      end
      if (i == 12) begin
        n_cmp++;
        if (done !== 1'b0 || tenths !== 4'd9) begin
          $display("FAIL pr_pre got done=%0b tenths=%0d req 0/9", done, tenths); n_err++;
        end
      end
      if (i < 13) step();
    end
    n_cmp++;
    if (timeout_pulse !== 1'b1 || done !== 1'b1 || timeout_cnt !== 0) begin
      $display("FAIL pr_expire got to=%0b done=%0b early=%0d req 1/1/0", timeout_pulse, done, timeout_cnt); n_err++;
    end
    do_abort();
  endtask

  task automatic test_tick_pause();
    do_start(8'd5);
    for (int i = 0; i < 4; i++) begin do_tick(); step(); end
    tick_100ms = 1'b1; pause = 1'b1; step(); tick_100ms = 1'b0; pause = 1'b0;
    n_cmp++;
    if (tenths !== 4'd4 || paused !== 1'b1 || secs_remaining !== 8'd5) begin
      $display("FAIL tp_pause got tenths=%0d paused=%0b secs=%0d req 4/1/5", tenths, paused, secs_remaining); n_err++;
    end
    do_abort();
  endtask

  task automatic test_zero_load();
    timeout_cnt = 0;
    do_start(8'd0);
    n_cmp++;
    if (done !== 1'b1 || timeout_pulse !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL zl_expire got done=%0b to=%0b busy=%0b req 1/1/0", done, timeout_pulse, busy); n_err++;
    end
    idle(3);
    n_cmp++;
    if (timeout_cnt !== 1 || done !== 1'b1) begin
      $display("FAIL zl_single got pulses=%0d done=%0b req 1/1", timeout_cnt, done); n_err++;
    end
    do_abort();
  endtask

  task automatic test_abort_corner();
    do_start(8'd1);
    for (int i = 0; i < 9; i++) begin do_tick(); step(); end
    n_cmp++;
    if (secs_remaining !== 8'd1 || tenths !== 4'd9) begin
      $display("FAIL ab_setup got secs=%0d tenths=%0d req 1/9", secs_remaining, tenths); n_err++;
    end
    timeout_cnt = 0;
    abort = 1'b1; tick_100ms = 1'b1; step(); abort = 1'b0; tick_100ms = 1'b0;
    idle(3);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || secs_remaining !== 8'd0 || tenths !== 4'd0 || timeout_cnt !== 0) begin
      $display("FAIL ab_idle got busy=%0b done=%0b secs=%0d tenths=%0d pulses=%0d req 0/0/0/0/0",
               busy, done, secs_remaining, tenths, timeout_cnt); n_err++;
    end
  endtask

  task automatic test_reset_midrun();
    do_start(8'd4);
    for (int i = 0; i < 3; i++) begin do_tick(); step(); end
    timeout_cnt = 0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({secs_remaining, tenths, busy, paused, done, timeout_pulse} !== '0) begin
      $display("FAIL rs_async got secs=%0d tenths=%0d busy=%0b req all 0", secs_remaining, tenths, busy); n_err++;
    end
    step();
    rst = 1'b0;
    idle(2);
    n_cmp++;
    if (busy !== 1'b0 || timeout_cnt !== 0) begin
      $display("FAIL rs_after got busy=%0b pulses=%0d req 0/0", busy, timeout_cnt); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    do_start(8'd9);
    for (int i = 0; i < 5; i++) begin do_tick(); step(); end
    load_secs = 8'd3; start = 1'b1; tick_100ms = 1'b1; step(); start = 1'b0; tick_100ms = 1'b0;
    n_cmp++;
    if (secs_remaining !== 8'd3 || tenths !== 4'd0 || busy !== 1'b1) begin
      $display("FAIL bb_restart got secs=%0d tenths=%0d busy=%0b req 3/0/1", secs_remaining, tenths, busy); n_err++;
    end
    pause = 1'b1; step(); pause = 1'b0;
    do_start(8'd6);
    n_cmp++;
    if (secs_remaining !== 8'd6 || paused !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL bb_pause_start got secs=%0d paused=%0b busy=%0b req 6/0/1", secs_remaining, paused, busy); n_err++;
    end
    do_abort();
  endtask

`ifdef TIMER_WARN_EN
  task automatic test_warn();
    warn_cnt = 0;
    do_start(8'd7);
    for (int i = 1; i <= 70; i++) begin
      do_tick();
      if (i == 20) begin
        n_cmp++;
        if (warn_pulse !== 1'b1 || secs_remaining !== 8'd5) begin
          $display("FAIL wn_at5 got warn=%0b secs=%0d req 1/5", warn_pulse, secs_remaining); n_err++;
        end
      end
    end
    step();
    n_cmp++;
    if (warn_cnt !== 1 || done !== 1'b1) begin
      $display("FAIL wn_single got pulses=%0d done=%0b req 1/1", warn_cnt, done); n_err++;
    end
    do_abort();
    warn_cnt = 0;
    do_start(8'd3);
    step();
    n_cmp++;
    if (warn_cnt !== 1) begin
      $display("FAIL wn_load got pulses=%0d req 1", warn_cnt); n_err++;
    end
    do_abort();
  endtask
`endif

  initial begin
    warn_cnt = 0;
    test_reset();
    test_countdown();
    test_pause_resume();
    test_tick_pause();
    test_zero_load();
    test_abort_corner();
    test_reset_midrun();
    test_back_to_back();
`ifdef TIMER_WARN_EN
    test_warn();
`else
    n_cmp++;
    if (warn_cnt !== 0) begin
      $display("FAIL warn_off got pulses=%0d req 0", warn_cnt); n_err++;
    end
`endif
    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Controller that sequences the 100 ms tick datapath into a pausable, abortable seconds countdown.
- Loads a seconds value, counts TICKS_PER_SEC ticks per second and decrements the remaining seconds.
- Raises a single-cycle timeout pulse and holds a done flag when the count reaches zero.
- Sits between the 100 ms tick generator and the game/access FSM, replacing fixed-length second counters with a controllable one.

Parameters:
SEC_W, 8, width of seconds load value and remaining-seconds count
TICKS_PER_SEC, 10, tick_100ms pulses per second (≥2)
WARN_SECS, 5, remaining-seconds threshold for warning pulse (TIMER_WARN_EN only)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
tick_100ms  input  1  single-cycle 100 ms pulse from tick generator
start  input  1  load load_secs and begin countdown
pause  input  1  freeze countdown
resume  input  1  continue paused countdown
abort  input  1  cancel, return to IDLE
load_secs  input  SEC_W  seconds to count, sampled on accepted start
secs_remaining  output  SEC_W  whole seconds left
tenths  output  4  ticks elapsed in current second, 0..TICKS_PER_SEC-1
busy  output  1  high in RUN or PAUSE
paused  output  1  high in PAUSE
done  output  1  high in EXPIRED
timeout_pulse  output  1  one-cycle pulse on entry to EXPIRED
warn_pulse  output  1  one-cycle warning pulse (tied 0 without TIMER_WARN_EN)

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0; secs_remaining=0, tenths=0.
  - Reset mid-count discards all progress; no pulse is emitted.
- All outputs are registered. Command priority each cycle: abort > start > pause/resume > tick.
- IDLE:
  - start with load_secs≠0 → RUN next cycle; secs_remaining=load_secs, tenths=0.
  - start with load_secs=0 → EXPIRED next cycle; timeout_pulse=1 that cycle.
  - Ticks are ignored.
- RUN:
  - On tick with tenths<TICKS_PER_SEC-1: tenths+1.
  - On tick with tenths=TICKS_PER_SEC-1: tenths=0, secs_remaining-1.
  - If that decrement takes secs_remaining from 1 to 0: → EXPIRED, timeout_pulse=1 for one cycle.
  - pause → PAUSE; a tick in the same cycle is dropped.
  - start → reload from load_secs (restart), tenths=0; a tick in the same cycle is dropped.
  - resume has no effect.
- PAUSE:
  - Counters frozen; ticks ignored.
  - resume → RUN; a tick in the same cycle is dropped.
  - start → reload, then RUN.
  - pause has no effect.
  - If pause and resume are asserted together, pause wins (stay PAUSE).
- EXPIRED:
  - done=1; secs_remaining=0, tenths=0.
  - Holds until start (reload, RUN or EXPIRED per load_secs rule) or abort (→ IDLE).
  - Ticks, pause and resume are ignored.
- abort in any state → IDLE next cycle; counters cleared; no timeout_pulse.
- Latency:
  - Command to state/output change is 1 cycle.
  - Final tick to timeout_pulse is 1 cycle (registered).
- Arithmetic: secs_remaining never wraps; the decrement is performed only when the value is ≥1.

Optional Feature:
- Macro TIMER_WARN_EN.
- When defined:
  - warn_pulse=1 for one cycle when a RUN-state decrement makes secs_remaining equal WARN_SECS.
  - Also asserted when start loads a value ≤WARN_SECS and ≠0 (pulse in the cycle RUN is entered).
  - Never asserted in PAUSE, EXPIRED or IDLE.
- When undefined: warn_pulse is constant 0 and no comparator logic is built.

Test Plan:
- Reset, start with load_secs=3, 30 ticks spaced 5 cycles apart:
  - secs_remaining steps 3→2→1→0 at ticks 10, 20 and 30.
  - timeout_pulse is high exactly 1 cycle after tick 30; done stays 1.
- load_secs=2, pause after 7 ticks, apply 20 ticks, then resume and apply 13 ticks:
  - Frozen at secs=2, tenths=7 while paused.
  - Expires on the 13th tick after resume.
- Tick and pause in the same cycle with tenths=4: pause wins, tenths stays 4, paused=1.
- start with load_secs=0 from IDLE → done=1 and a single timeout_pulse next cycle.
- Corner cases:
  - abort at secs=1, tenths=9 coincident with tick → IDLE, no timeout_pulse.
  - rst asserted mid-run → all outputs 0 immediately.
- TIMER_WARN_EN, WARN_SECS=5, load_secs=7 → single warn_pulse at the 7→... decrement reaching 5; none at 4..0.
